// File: rtl/ones_count_arb.sv
// Two-requester round-robin popcount scheduler over one shared 8-bit ones_count datapath.
// Latency: NBYTES cycles from accept to rsp_valid; with ONES_COUNT_ARB_SKIP_EN, zero upper bytes are skipped (min 1).
// Backpressure: requests are refused outside IDLE; the response holds stable until rsp_ready.

module ones_count (
    input  logic [7:0] dat_in,
    output logic [3:0] count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, dat_in[i]};
        end
    end
endmodule

module ones_count_arb #(
    parameter  int NBYTES = 4,
    localparam int W      = 8 * NBYTES,
    localparam int CW     = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [W-1:0]  req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [W-1:0]  req1_data,
    output logic          req1_ready,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [CW-1:0] rsp_count
);
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last_id;
    logic          cur_id;
    logic [W-1:0]  shreg;
    logic [CW-1:0] acc;
    logic [IW-1:0] idx;
    logic [3:0]    byte_cnt;
    logic          grant;
    logic          accept;
    logic          run_done;

    ones_count u_ones_count (
        .dat_in (shreg[7:0]),
        .count  (byte_cnt)
    );

`ifdef ONES_COUNT_ARB_SKIP_EN
    // Stop early once every byte still waiting in the shift register is zero.
    assign run_done = (idx == IW'(NBYTES - 1)) || ((shreg >> 8) == '0);
`else
    assign run_done = (idx == IW'(NBYTES - 1));
`endif

    // Contested grant goes to whichever requester was not served last.
    assign grant = (req0_valid && req1_valid) ? ~last_id : req1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = req0_valid && !grant;
                req1_ready = req1_valid && grant;
                accept     = req0_valid || req1_valid;
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (run_done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            acc     <= '0;
            idx     <= '0;
            cur_id  <= 1'b0;
            last_id <= 1'b1;
        end else begin
            if (accept) begin
                shreg  <= grant ? req1_data : req0_data;
                acc    <= '0;
                idx    <= '0;
                cur_id <= grant;
            end else if (state == RUN) begin
                acc   <= acc + CW'(byte_cnt);
                shreg <= shreg >> 8;
                idx   <= idx + IW'(1);
            end else if (state == RESP && rsp_ready) begin
                last_id <= cur_id;
            end
        end
    end

    assign rsp_valid = (state == RESP);
    assign rsp_id    = cur_id;
    assign rsp_count = acc;

endmodule

// File: tb/tb_ones_count_arb.sv
// Directed bench for ones_count_arb: transaction-level model checked every cycle,
// plus literal expectations on responses, ordering and latency.

module tb_ones_count_arb;
    localparam int NB = 4;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [5:0]  rsp_count;

    int passed = 0;
    int total  = 0;

    ones_count_arb #(.NBYTES(NB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_count  (rsp_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int lat_of(input logic [31:0] w);
        int n;
        n = NB;
`ifdef ONES_COUNT_ARB_SKIP_EN
        n = 1;
        for (int b = 0; b < NB; b++) if (w[8*b +: 8] != 8'h00) n = b + 1;
`endif
        return n;
    endfunction

    // Model state: remaining RUN cycles, pending response, round-robin memory.
    int          m_run = 0;
    bit          m_resp = 0;
    int          m_count = 0;
    bit          m_id = 0;
    bit          m_last = 1;
    bit          g;
    logic [31:0] w;

    // Observed DUT history.
    int cyc = 0;
    int acc_cyc = 0;
    int last_lat = 0;
    bit prev_vld = 0;
    int log_id[$];
    int log_cnt[$];
    int log_lat[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_run = 0; m_resp = 0; m_last = 1;
        end
        g = (req0_valid && req1_valid) ? !m_last : req1_valid;
        chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
        chk("req0_ready", 32'(req0_ready), 32'(m_run == 0 && !m_resp && req0_valid && !g));
        chk("req1_ready", 32'(req1_ready), 32'(m_run == 0 && !m_resp && req1_valid && g));
        if (m_resp) begin
            chk("rsp_count", 32'(rsp_count), 32'(m_count));
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
        end
        if (!rst_n) begin
            chk("rst_count", 32'(rsp_count), 32'd0);
            chk("rst_id", 32'(rsp_id), 32'd0);
        end

        // DUT-observed history for latency and ordering checks.
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc_cyc = cyc;
        if (rsp_valid && !prev_vld) last_lat = cyc - 1 - acc_cyc;
        if (rsp_valid && rsp_ready) begin
            log_id.push_back(int'(rsp_id));
            log_cnt.push_back(int'(rsp_count));
            log_lat.push_back(last_lat);
        end
        prev_vld = rsp_valid && rst_n;

        if (rst_n) begin
            if (m_resp) begin
                if (rsp_ready) begin
                    m_resp = 0;
                    m_last = m_id;
                end
            end else if (m_run > 0) begin
                m_run--;
                if (m_run == 0) m_resp = 1;
            end else if (req0_valid || req1_valid) begin
                w       = g ? req1_data : req0_data;
                m_count = $countones(w);
                m_id    = g;
                m_run   = lat_of(w);
            end
        end
    end

    task automatic send(input bit id, input logic [31:0] d);
        bit ok;
        ok = 0;
        if (id) begin req1_valid = 1; req1_data = d; end
        else    begin req0_valid = 1; req0_data = d; end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((!id && req0_ready) || (id && req1_ready)) begin ok = 1; break; end
        end
        if (!ok) begin total++; $display("FAIL accept_timeout: no accept for id %0d", id); end
        @(posedge clk); #1;
        if (id) req1_valid = 0; else req0_valid = 0;
    endtask

    task automatic wait_rsp();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin ok = 1; break; end
        end
        if (!ok) begin total++; $display("FAIL rsp_timeout: no response handshake"); end
        @(posedge clk); #1;
    endtask

    task automatic check_entry(input string nm, input int k, input int id, input int cnt, input int lat);
        if (k < 0 || k >= log_id.size()) begin
            total++;
            $display("FAIL %s: response %0d missing, log size %0d", nm, k, log_id.size());
        end else begin
            chk({nm, "_id"}, 32'(log_id[k]), 32'(id));
            chk({nm, "_count"}, 32'(log_cnt[k]), 32'(cnt));
            if (lat >= 0) chk({nm, "_lat"}, 32'(log_lat[k]), 32'(lat));
        end
    endtask

    int base;
    int lat_skip;

    initial begin
`ifdef ONES_COUNT_ARB_SKIP_EN
        lat_skip = 1;
`else
        lat_skip = 4;
`endif
        rst_n = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_data = '0; req1_data = '0;

        // Reset state, and combinational ready while held in reset.
        repeat (2) @(posedge clk); #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_count", 32'(rsp_count), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_req0_ready", 32'(req0_ready), 32'd0);
        chk("reset_req1_ready", 32'(req1_ready), 32'd0);
        req0_valid = 1; req0_data = 32'hDEAD_BEEF;
        #1 chk("reset_req0_ready_hi", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        req0_valid = 0; rst_n = 1;
        repeat (6) @(posedge clk); #1;
        chk("reset_no_capture", 32'(log_id.size()), 32'd0);

        // Single request: bytes 2+6+3+4.
        rsp_ready = 1;
        send(0, 32'h8B89_EB0A);
        wait_rsp();
        check_entry("single", log_id.size() - 1, 0, 15, 4);

        // Contention from reset: strict alternation starting with req0.
        rst_n = 0;
        @(posedge clk); #1;
        req0_valid = 1; req0_data = 32'hFFFF_FFFF;
        req1_valid = 1; req1_data = 32'h0000_000F;
        @(posedge clk); #1;
        rst_n = 1;
        base = log_id.size();
        repeat (4) wait_rsp();
        req0_valid = 0; req1_valid = 0;
        check_entry("cont0", base,     0, 32, 4);
        check_entry("cont1", base + 1, 1, 4, lat_skip);
        check_entry("cont2", base + 2, 0, 32, 4);
        check_entry("cont3", base + 3, 1, 4, lat_skip);
        repeat (2) @(posedge clk); #1;

        // Backpressure with req1 waiting behind the held response.
        rsp_ready = 0;
        send(0, 32'h1234_5678);
        req1_valid = 1; req1_data = 32'h0000_00F0;
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (rsp_valid) begin seen = 1; break; end
            end
            if (!seen) begin total++; $display("FAIL bp_timeout: rsp_valid never rose"); end
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_count", 32'(rsp_count), 32'd13);
            chk("bp_id", 32'(rsp_id), 32'd0);
            chk("bp_req0_ready", 32'(req0_ready), 32'd0);
            chk("bp_req1_ready", 32'(req1_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_next_accept", 32'(req1_ready), 32'd1);
        @(posedge clk); #1;
        req1_valid = 0;
        check_entry("bp_rsp", log_id.size() - 1, 0, 13, 4);
        wait_rsp();
        check_entry("bp_waiter", log_id.size() - 1, 1, 4, lat_skip);

        // Zero upper bytes and all-zero word.
        send(1, 32'h0000_00FF);
        wait_rsp();
        check_entry("skip_ff", log_id.size() - 1, 1, 8, lat_skip);
        send(1, 32'h0000_0000);
        wait_rsp();
        check_entry("skip_zero", log_id.size() - 1, 1, 0, lat_skip);

        // Reset during the second RUN cycle discards the word.
        base = log_id.size();
        req0_valid = 1; req0_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        req0_valid = 0;
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        repeat (8) @(posedge clk); #1;
        chk("midrst_no_rsp", 32'(log_id.size()), 32'(base));
        send(0, 32'h0000_0000);
        wait_rsp();
        check_entry("midrst_next", log_id.size() - 1, 0, 0, lat_skip);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ones_count_arb.md
# ones_count_arb

Two-requester round-robin scheduler that time-shares one 8-bit `ones_count` datapath (8-bit `dat_in`, 4-bit `count`) to compute the population count of multi-byte words. Each accepted word is streamed through the shared `ones_count` instance one byte per cycle, least-significant byte first, and the per-byte counts are accumulated. The total is returned on a valid/ready response port tagged with the requester id. The block sits between two client engines and the single `ones_count` instance.

## Interface
- `NBYTES`, default 4: bytes per request word; must be ≥1. `W` = 8*NBYTES. `CW` = $clog2(W+1) (6 when NBYTES=4).
- `clk`  in  1  the block's single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req0_valid`  in  1  requester 0 has a word.
- `req0_data`  in  W  requester 0 word.
- `req0_ready`  out  1  requester 0 word accepted this cycle.
- `req1_valid`, `req1_data`, `req1_ready`: same as the req0 ports, for requester 1.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  1  requester that owns the result.
- `rsp_count`  out  CW  population count of the word.

## Operation
- FSM states:
  - IDLE: no word in flight. `reqN_ready` is combinational: high only for the granted requester, and only while that requester's valid is high.
    - Grant: if only one valid is high, that requester. If both are high, the requester that was not granted last (`last_id`).
    - Handshake when `reqN_valid` && `reqN_ready`: latch data into the shift register, clear the accumulator and byte index, set `cur_id`, go to RUN.
  - RUN: on each cycle:
    - Drive the low byte of the shift register into `ones_count.dat_in`.
    - Accumulator += zero-extended `count`.
    - Shift register >>= 8; index++.
    - After the byte with index NBYTES-1 is processed, go to RESP.
  - RESP: `rsp_valid`=1, `rsp_count`=accumulator, `rsp_id`=`cur_id`. Hold until `rsp_ready`. On the handshake edge: `last_id`=`cur_id`, go to IDLE.
- Both `reqN_ready` are 0 in RUN and RESP. A requester that holds valid is served only once the block returns to IDLE.
- A requester may drop valid before its handshake; grant is re-evaluated every IDLE cycle.
- Width rules:
  - Accumulator is CW bits and cannot overflow, since the maximum value W fits in CW bits.
  - The 4-bit `count` is zero-extended before the add.
- Reset values: state=IDLE, `last_id`=1 (req0 wins the first contest), `rsp_valid`=0, `rsp_id`=0, `rsp_count`=0, accumulator=0, shift register=0. `reqN_ready` is 0 unless the corresponding valid is high.
- Reset mid-operation: an in-flight word is discarded and no response is issued. The next request is counted from a cleared accumulator.

## Timing
- IDLE accept edge T: RUN occupies the cycles after T. `rsp_valid` rises NBYTES cycles after T (4 for the default).
- `rsp_count`, `rsp_id` and `rsp_valid` are registered and remain stable while `rsp_valid`=1 and `rsp_ready`=0.
- The earliest next accept is the cycle after the response handshake. Minimum spacing between accepts is NBYTES+2 cycles.
- `rsp_ready` may be high before `rsp_valid`; the handshake then completes on the first RESP edge.

## Configuration
- `ONES_COUNT_ARB_SKIP_EN` defined:
  - RUN also exits to RESP right after the current byte when the post-shift register is all zero.
  - Zero upper bytes are skipped, so latency is (index of highest nonzero byte + 1) cycles, minimum 1. A zero word takes 1 RUN cycle.
- `ONES_COUNT_ARB_SKIP_EN` undefined: RUN always lasts exactly NBYTES cycles.
- Results are identical in both builds; only latency differs.

## Test plan
- Reset: hold `rst_n`=0 with both valids at 0 → `rsp_valid`=0, `rsp_count`=0, `rsp_id`=0, both readys 0. Asserting `req0_valid` while `rst_n`=0 raises `req0_ready`, and no capture occurs.
- Single request: req0 `32'h8B89_EB0A`, `rsp_ready`=1 → bytes counted 2, 6, 3, 4. `rsp_count`=15 and `rsp_id`=0, 4 cycles after the accept edge.
- Contention: both valids held high from reset with `32'hFFFF_FFFF` (req0) and `32'h0000_000F` (req1) → responses arrive in id order 0, 1, 0, 1 with counts 32, 4, 32, 4.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP → outputs stable, both readys 0. Raising `rsp_ready` completes the handshake, and IDLE accepts the waiting requester on the next cycle.
- Skip feature: req1 `32'h0000_00FF` → count 8. With `ONES_COUNT_ARB_SKIP_EN`, `rsp_valid` rises 1 cycle after accept; without it, 4 cycles. Word 0 → count 0, with latency 1 or 4 cycles respectively.
- Mid-run reset: pulse `rst_n` low during the second RUN cycle → no response is issued. The next req0 `32'h0000_0000` yields count 0 and id 0.
